// File: rtl/exec_trace_monitor_if.sv
// exec_trace_monitor_if
// Trace drain port between the run monitor and its host (bench, debug logic).
// Show-ahead valid/ready: the head entry is presented while tr_valid=1 and is
// consumed on any edge where tr_valid and tr_ready are both high.
//   tr_valid  monitor -> host  head entry present
//   tr_ready  host -> monitor  host takes the head this cycle
//   tr_cycle  monitor -> host  cycle stamp of the writeback
//   tr_reg    monitor -> host  destination register
//   tr_data   monitor -> host  value written
interface exec_trace_monitor_if #(
  parameter int CNT_BITS  = 16,
  parameter int REG_BITS  = 5,
  parameter int DATA_BITS = 32
);
  logic                 tr_valid;
  logic                 tr_ready;
  logic [CNT_BITS-1:0]  tr_cycle;
  logic [REG_BITS-1:0]  tr_reg;
  logic [DATA_BITS-1:0] tr_data;

  modport master (
    output tr_valid,
    output tr_cycle,
    output tr_reg,
    output tr_data,
    input  tr_ready
  );

  modport slave (
    input  tr_valid,
    input  tr_cycle,
    input  tr_reg,
    input  tr_data,
    output tr_ready
  );
endinterface

// File: rtl/exec_trace_monitor.sv
// exec_trace_monitor
// Run controller and writeback trace buffer for the single-cycle processor.
// Holds the core in stall until started, lets it run for a programmable
// number of cycles (or until halted), and timestamps every register-file
// writeback into a show-ahead FIFO drained by the host.
// Ports:
//   clk, reset            clock, async active-low reset
//   start, halt_req       arm a run (IDLE/DONE), end a run early (RUN)
//   cfg_limit             cycle budget, 0 = unlimited, latched on start
//   pc                    current fetch PC of the core
//   wb_en/wb_reg/wb_data  register-file write port of the core
//   proc_stall            1 = core must hold state
//   state, done           run state, high in DONE
//   cycle_count, last_pc  executed cycles this run, pc of last executed cycle
//   overflow              sticky: a trace entry was dropped this run
//   trc                   trace drain port (master side)
//
// state | meaning
// IDLE  | after reset, core stalled, waiting for start
// RUN   | core executing, writebacks captured
// DRAIN | core stalled, waiting for the host to empty the trace FIFO
// DONE  | run finished, trace empty, waiting for start
module exec_trace_monitor #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int REG_BITS  = 5,
  parameter int DEPTH     = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic [CNT_BITS-1:0]  cfg_limit,
  input  logic [ADDR_BITS-1:0] pc,
  input  logic                 wb_en,
  input  logic [REG_BITS-1:0]  wb_reg,
  input  logic [DATA_BITS-1:0] wb_data,
  output logic                 proc_stall,
  output logic [1:0]           state,
  output logic [CNT_BITS-1:0]  cycle_count,
  output logic [ADDR_BITS-1:0] last_pc,
  output logic                 overflow,
  output logic                 done,
  exec_trace_monitor_if.master trc
);

  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int PTR_BITS = IDX_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CNT_BITS-1:0]  cyc;
    logic [REG_BITS-1:0]  rd;
    logic [DATA_BITS-1:0] val;
  } entry_t;

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  limit_q;
  logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
  entry_t               mem [DEPTH];
  entry_t               head;

  logic arm;
  logic in_run;
  logic limit_hit;
  logic full, empty;
  logic capture, push, pop, drop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_BITS-1:0] == rd_ptr[IDX_BITS-1:0]) &&
                 (wr_ptr[IDX_BITS] != rd_ptr[IDX_BITS]);

  assign in_run    = (state_q == RUN);
  assign limit_hit = (limit_q != '0) && (cycle_count == limit_q - CNT_BITS'(1));

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign pop     = !empty && trc.tr_ready;
  assign capture = in_run && wb_en && (wb_reg != '0);
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          arm     = 1'b1;
        end
      end
      RUN: begin
        if (halt_req || limit_hit) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      limit_q     <= '0;
      cycle_count <= '0;
      last_pc     <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        limit_q     <= cfg_limit;
        cycle_count <= '0;
        overflow    <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (in_run) begin
          last_pc <= pc;
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_BITS'(1);
        end
        if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset: contents are only observed behind tr_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_BITS-1:0]] <= '{cyc: cycle_count, rd: wb_reg, val: wb_data};
  end

  assign head         = mem[rd_ptr[IDX_BITS-1:0]];
  assign trc.tr_valid = !empty;
  assign trc.tr_cycle = head.cyc;
  assign trc.tr_reg   = head.rd;
  assign trc.tr_data  = head.val;

  assign proc_stall = !in_run;
  assign done       = (state_q == DONE);
  assign state      = state_q;

endmodule

// File: tb/tb_exec_trace_monitor.sv
module tb_exec_trace_monitor;
  localparam int AB = 32, DB = 32, RB = 5, DEPTH = 4, CB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic [CB-1:0] cfg_limit = '0;
  logic [AB-1:0] pc = '0;
  logic          wb_en = 1'b0;
  logic [RB-1:0] wb_reg = '0;
  logic [DB-1:0] wb_data = '0;
  logic          proc_stall, overflow, done;
  logic [1:0]    state;
  logic [CB-1:0] cycle_count;
  logic [AB-1:0] last_pc;

  exec_trace_monitor_if #(.CNT_BITS(CB), .REG_BITS(RB), .DATA_BITS(DB)) trc();

  exec_trace_monitor #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .REG_BITS(RB), .DEPTH(DEPTH), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .cfg_limit(cfg_limit), .pc(pc), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .proc_stall(proc_stall), .state(state),
    .cycle_count(cycle_count), .last_pc(last_pc), .overflow(overflow),
    .done(done), .trc(trc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CB-1:0] c;
    logic [RB-1:0] r;
    logic [DB-1:0] d;
  } ent_t;

  int total = 0;
  int bad = 0;

  // Reference model: run phase 0..3, a bounded queue for the trace.
  ent_t          mq[$];
  int            m_state;
  logic [CB-1:0] m_count, m_limit;
  logic [AB-1:0] m_pc;
  logic          m_ovf;

  int            stall_low;
  ent_t          popped[$];
  logic [DB-1:0] d3 [6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_count = '0;
    m_limit = '0;
    m_pc    = '0;
    m_ovf   = 1'b0;
    mq.delete();
  endtask

  task automatic check_outputs();
    chk("state", 64'(state), 64'(m_state));
    chk("proc_stall", 64'(proc_stall), 64'(m_state != 1));
    chk("done", 64'(done), 64'(m_state == 3));
    chk("cycle_count", 64'(cycle_count), 64'(m_count));
    chk("last_pc", 64'(last_pc), 64'(m_pc));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("tr_valid", 64'(trc.tr_valid), 64'(mq.size() != 0));
    if (mq.size() != 0 && trc.tr_valid === 1'b1) begin
      chk("tr_cycle", 64'(trc.tr_cycle), 64'(mq[0].c));
      chk("tr_reg", 64'(trc.tr_reg), 64'(mq[0].r));
      chk("tr_data", 64'(trc.tr_data), 64'(mq[0].d));
    end
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit pop_now, cap;
    pop_now = (mq.size() != 0) && (trc.tr_ready == 1'b1);
    cap = (m_state == 1) && wb_en && (wb_reg != 0);
    case (m_state)
      0, 3: begin
        if (start) begin
          m_state = 1;
          m_count = '0;
          m_ovf   = 1'b0;
          m_limit = cfg_limit;
          mq.delete();
        end
      end
      1: begin
        if (pop_now) void'(mq.pop_front());
        if (cap) begin
          if (mq.size() < DEPTH) mq.push_back('{m_count, wb_reg, wb_data});
          else m_ovf = 1'b1;
        end
        m_pc = pc;
        if (halt_req || (m_limit != 0 && int'(m_count) + 1 == int'(m_limit))) m_state = 2;
        if (m_count != 16'hFFFF) m_count++;
      end
      default: begin
        if (mq.size() == 0) m_state = 3;
        if (pop_now) void'(mq.pop_front());
      end
    endcase
  endtask

  task automatic cyc();
    pc = $urandom;
    check_outputs();
    if (proc_stall === 1'b0) stall_low++;
    if (trc.tr_valid === 1'b1 && trc.tr_ready === 1'b1)
      popped.push_back('{trc.tr_cycle, trc.tr_reg, trc.tr_data});
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int budget);
    for (int n = 0; n < budget && done !== 1'b1; n++) cyc();
    chk("done_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    trc.tr_ready = 1'b0;
    model_reset();

    // Reset values while reset is held low.
    #3;
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Limit 5, writebacks r1..r5 with 10..50, host always ready.
    trc.tr_ready = 1'b1;
    cfg_limit = 16'd5;
    start = 1'b1;
    stall_low = 0;
    popped.delete();
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_en = 1'b1;
      wb_reg = 5'(i + 1);
      wb_data = 32'(10 * (i + 1));
      cyc();
    end
    wb_en = 1'b0;
    run_until_done(20);
    chk("t1_stall_cycles", 64'(stall_low), 64'(5));
    chk("t1_count", 64'(cycle_count), 64'(5));
    chk("t1_npop", 64'(popped.size()), 64'(5));
    for (int i = 0; i < popped.size(); i++) begin
      chk("t1_cyc", 64'(popped[i].c), 64'(i));
      chk("t1_reg", 64'(popped[i].r), 64'(i + 1));
      chk("t1_data", 64'(popped[i].d), 64'(10 * (i + 1)));
    end

    // r0 writebacks interleaved with r3: only r3 is traced.
    cfg_limit = 16'd8;
    start = 1'b1;
    popped.delete();
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wb_en = 1'b1;
      wb_reg = (i % 2 == 1) ? 5'd3 : 5'd0;
      wb_data = $urandom;
      trc.tr_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    wb_en = 1'b0;
    trc.tr_ready = 1'b1;
    run_until_done(20);
    chk("t2_overflow", 64'(overflow), 64'(0));
    chk("t2_npop", 64'(popped.size()), 64'(4));
    for (int i = 0; i < popped.size(); i++) chk("t2_reg", 64'(popped[i].r), 64'(3));

    // Six writebacks into a 4-deep FIFO with no host: last two dropped.
    trc.tr_ready = 1'b0;
    cfg_limit = 16'd6;
    start = 1'b1;
    popped.delete();
    cyc();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_en = 1'b1;
      wb_reg = 5'(i + 1);
      d3[i] = $urandom;
      wb_data = d3[i];
      cyc();
    end
    wb_en = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("t3_state_drain", 64'(state), 64'(2));
    chk("t3_overflow", 64'(overflow), 64'(1));
    trc.tr_ready = 1'b1;
    run_until_done(20);
    chk("t3_npop", 64'(popped.size()), 64'(4));
    for (int i = 0; i < popped.size(); i++) begin
      chk("t3_cyc", 64'(popped[i].c), 64'(i));
      chk("t3_reg", 64'(popped[i].r), 64'(i + 1));
      chk("t3_data", 64'(popped[i].d), 64'(d3[i]));
    end

    // Full FIFO with push and pop on the same edge, then a real drop.
    trc.tr_ready = 1'b0;
    cfg_limit = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_en = 1'b1;
      wb_reg = 5'(i + 1);
      wb_data = $urandom;
      cyc();
    end
    trc.tr_ready = 1'b1;
    wb_reg = 5'd7;
    wb_data = $urandom;
    cyc();
    trc.tr_ready = 1'b0;
    chk("t4_overflow_pushpop", 64'(overflow), 64'(0));
    popped.delete();
    wb_reg = 5'd9;
    cyc();
    chk("t4_overflow_drop", 64'(overflow), 64'(1));
    wb_en = 1'b0;
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    trc.tr_ready = 1'b1;
    run_until_done(20);
    chk("t4_npop", 64'(popped.size()), 64'(4));
    if (popped.size() == 4) begin
      chk("t4_first_cyc", 64'(popped[0].c), 64'(1));
      chk("t4_last_reg", 64'(popped[3].r), 64'(7));
    end

    // Unlimited run halted at cycle_count=3; start clears count and overflow.
    cfg_limit = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t5_count_cleared", 64'(cycle_count), 64'(0));
    chk("t5_ovf_cleared", 64'(overflow), 64'(0));
    for (int i = 0; i < 3; i++) cyc();
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk("t5_state", 64'(state), 64'(2));
    chk("t5_count", 64'(cycle_count), 64'(4));
    chk("t5_stall", 64'(proc_stall), 64'(1));
    run_until_done(20);

    // Random runs against the model.
    for (int r = 0; r < 20; r++) begin
      cfg_limit = 16'($urandom_range(0, 12));
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int n = 0; n < 40 && m_state == 1; n++) begin
        wb_en = 1'($urandom_range(0, 1));
        wb_reg = 5'($urandom_range(0, 31));
        wb_data = $urandom;
        trc.tr_ready = 1'($urandom_range(0, 1));
        halt_req = ($urandom_range(0, 15) == 0) || (n == 30);
        start = 1'($urandom_range(0, 1));
        cyc();
      end
      start = 1'b0;
      halt_req = 1'b0;
      wb_en = 1'b0;
      trc.tr_ready = 1'b1;
      run_until_done(40);
    end

    // Asynchronous reset mid-run with a non-empty trace.
    trc.tr_ready = 1'b0;
    cfg_limit = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_en = 1'b1;
      wb_reg = 5'(i + 4);
      wb_data = $urandom;
      cyc();
    end
    wb_en = 1'b0;
    chk("t7_fifo_nonempty", 64'(trc.tr_valid), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    trc.tr_ready = 1'b1;
    cfg_limit = 16'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wb_en = 1'b1;
    wb_reg = 5'd2;
    wb_data = 32'h1234;
    cyc();
    wb_en = 1'b0;
    run_until_done(20);
    chk("t7_fresh_count", 64'(cycle_count), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
